// File: rtl/seq_booth_multiplier_if.sv
// seq_booth_multiplier_if: start/busy/done multiply handshake with operands and product
interface seq_booth_multiplier_if #(parameter int WIDTH = 32);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     Mplr;
  logic [WIDTH-1:0]     Mcnd;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   Y;
  modport master (output start, signed_mode, Mplr, Mcnd, input busy, done, Y);
  modport slave  (input start, signed_mode, Mplr, Mcnd, output busy, done, Y);
endinterface

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: sequential radix-4 Booth multiplier, one triplet per cycle, signed or unsigned
module seq_booth_multiplier #(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   reset,
  seq_booth_multiplier_if.slave bus
);
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2*WIDTH + 4;
  localparam int ITER = WIDTH/2 + 1;
  localparam int CW   = $clog2(ITER + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [EW-1:0]      mplr_q, mplr_d;
  logic               prev_q, prev_d;
  logic [AW-1:0]      mcnd_q, mcnd_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic [2:0]         trip;
  logic [AW-1:0]      addend;
  // Multiplier shifts right and multiplicand left, so the triplet always sits in the low bits
  assign trip   = {mplr_q[1:0], prev_q};
  assign addend = (trip == 3'b001 || trip == 3'b010) ? mcnd_q :
                  (trip == 3'b011)                   ? mcnd_q << 1 :
                  (trip == 3'b101 || trip == 3'b110) ? -mcnd_q :
                  (trip == 3'b100)                   ? -(mcnd_q << 1) : '0;
  always_comb begin
    state_d = state_q;
    mplr_d  = mplr_q;
    prev_d  = prev_q;
    mcnd_d  = mcnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    if (state_q == RUN) begin
      acc_d  = acc_q + addend;
      mplr_d = {{2{mplr_q[EW-1]}}, mplr_q[EW-1:2]};
      prev_d = mplr_q[1];
      mcnd_d = mcnd_q << 2;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == CW'(ITER - 1)) begin
        y_d     = acc_d[2*WIDTH-1:0];
        state_d = DONE;
      end
    end else if (bus.start) begin
      mplr_d  = bus.signed_mode ? {{2{bus.Mplr[WIDTH-1]}}, bus.Mplr} : {2'b00, bus.Mplr};
      mcnd_d  = bus.signed_mode ? {{(AW-WIDTH){bus.Mcnd[WIDTH-1]}}, bus.Mcnd}
                                : {{(AW-WIDTH){1'b0}}, bus.Mcnd};
      prev_d  = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mplr_q  <= '0;
      prev_q  <= 1'b0;
      mcnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      mplr_q  <= mplr_d;
      prev_q  <= prev_d;
      mcnd_q  <= mcnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.Y    = y_q;
endmodule
